// File: rtl/serial_tx_scheduler.sv
// Frame scheduler for the serial result transmitter: arbitrates result and heartbeat
// frames, locks the result RAM during a frame, and tracks completion or stall timeout.
module serial_tx_scheduler #(
    parameter int unsigned FRAME_BYTES      = 34,
    parameter int unsigned HEARTBEAT_CYCLES = 50000000,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000,
    parameter logic [7:0]  RESULT_HEADER    = 8'hA5,
    parameter logic [7:0]  HEARTBEAT_HEADER = 8'h5A
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        result_req_i,
    input  logic [7:0]  result_status_i,
    input  logic [7:0]  hb_status_i,
    input  logic        tx_busy_i,
    input  logic        tx_new_data_i,
    output logic        transmit_o,
    output logic [7:0]  header_byte_o,
    output logic [7:0]  status_byte_o,
    output logic        ram_lock_o,
    output logic        result_ack_o,
    output logic        error_o,
    output logic [15:0] frames_sent_o
);

    localparam int unsigned BYTE_W = $clog2(FRAME_BYTES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HB_W   = $clog2(HEARTBEAT_CYCLES + 1);
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_START,
        ST_COUNT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              res_pend_q;
    logic              res_pend_d;
    logic              hb_pend_q;
    logic              hb_pend_d;
    logic              rearm_q;
    logic              rearm_d;
    logic              is_result_q;
    logic              is_result_d;
    logic [HB_W-1:0]   hb_timer_q;
    logic [HB_W-1:0]   hb_timer_d;
    logic [BYTE_W-1:0] byte_cnt_q;
    logic [BYTE_W-1:0] byte_cnt_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;
    logic [CNT_W-1:0]  frames_cnt_q;
    logic [CNT_W-1:0]  frames_cnt_d;

    logic              transmit_d;
    logic              ram_lock_d;
    logic              result_ack_d;
    logic              error_d;
    logic [7:0]        header_d;
    logic [7:0]        status_d;

    logic              grant;
    logic              hb_expire;
    logic              last_byte;
    logic              timeout_hit;
    logic              done_res;
    logic              done_hb;

    assign grant       = (state_q == ST_IDLE) && (res_pend_q || hb_pend_q);
    assign hb_expire   = (hb_timer_q == HB_LAST);
    assign last_byte   = (state_q == ST_COUNT) && tx_new_data_i && (byte_cnt_q == LAST_BYTE);
    assign timeout_hit = (state_q == ST_COUNT) && !tx_new_data_i && (to_cnt_q == TO_LAST);
    assign done_res    = (state_q == ST_DONE) && is_result_q;
    assign done_hb     = (state_q == ST_DONE) && !is_result_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant) state_d = ST_LOCK;
            ST_LOCK:  if (!tx_busy_i) state_d = ST_START;
            ST_START: state_d = ST_COUNT;
            ST_COUNT: begin
                if (last_byte) begin
                    state_d = ST_DRAIN;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: if (!tx_busy_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered from the next state
    always_comb begin
        transmit_d   = (state_d == ST_START);
        ram_lock_d   = (state_d != ST_IDLE);
        result_ack_d = (state_d == ST_DONE) && is_result_q;
        header_d     = header_byte_o;
        status_d     = status_byte_o;
        is_result_d  = is_result_q;
        error_d      = error_o;
        byte_cnt_d   = byte_cnt_q;
        to_cnt_d     = to_cnt_q;
        frames_cnt_d = frames_cnt_q;
        hb_timer_d   = hb_expire ? '0 : hb_timer_q + HB_W'(1);

        if (grant) begin
            is_result_d = res_pend_q;
            header_d    = res_pend_q ? RESULT_HEADER : HEARTBEAT_HEADER;
            status_d    = res_pend_q ? result_status_i : hb_status_i;
        end

        if (state_q == ST_START) begin
            byte_cnt_d = '0;
            to_cnt_d   = '0;
        end else if (state_q == ST_COUNT) begin
            if (tx_new_data_i) begin
                byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                to_cnt_d   = '0;
            end else begin
                to_cnt_d   = to_cnt_q + TO_W'(1);
            end
        end

        if (timeout_hit) begin
            error_d = 1'b1;
        end else if (state_d == ST_START) begin
            error_d = 1'b0;
        end

        if ((state_q == ST_DONE) && !error_o) begin
            frames_cnt_d = frames_cnt_q + CNT_W'(1);
        end

        // A request seen after the grant must survive the DONE clear of its own frame
        rearm_d    = (state_q == ST_DONE) ? 1'b0
                   : (rearm_q || (result_req_i && (state_q != ST_IDLE)));
        res_pend_d = result_req_i || (done_res ? rearm_q : res_pend_q);
        hb_pend_d  = hb_expire || (hb_pend_q && !done_hb);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            transmit_o    <= 1'b0;
            ram_lock_o    <= 1'b0;
            result_ack_o  <= 1'b0;
            error_o       <= 1'b0;
            header_byte_o <= '0;
            status_byte_o <= '0;
            is_result_q   <= 1'b0;
            res_pend_q    <= 1'b0;
            hb_pend_q     <= 1'b0;
            rearm_q       <= 1'b0;
            hb_timer_q    <= '0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            frames_cnt_q  <= '0;
        end else begin
            transmit_o    <= transmit_d;
            ram_lock_o    <= ram_lock_d;
            result_ack_o  <= result_ack_d;
            error_o       <= error_d;
            header_byte_o <= header_d;
            status_byte_o <= status_d;
            is_result_q   <= is_result_d;
            res_pend_q    <= res_pend_d;
            hb_pend_q     <= hb_pend_d;
            rearm_q       <= rearm_d;
            hb_timer_q    <= hb_timer_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            frames_cnt_q  <= frames_cnt_d;
        end
    end

    assign frames_sent_o = frames_cnt_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: table-driven result frames plus hand sequences for
// timeout, re-arm, counter wrap, mid-frame reset and result/heartbeat priority.
module tb_serial_tx_scheduler;

    typedef struct packed {
        logic [7:0] hdr;
        logic [7:0] st;
    } exp_t;

    typedef struct {
        logic [7:0] status;
        int         busy_pre;
        int         gap;
        int         exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_a, rst_b, req_a, req_b;
    logic [7:0]  res_status, hb_status;
    logic        tx_busy, new_data;

    logic        a_tx, a_lock, a_ack, a_err;
    logic [7:0]  a_hdr, a_st;
    logic [15:0] a_frames;
    logic        b_tx, b_lock, b_ack, b_err;
    logic [7:0]  b_hdr, b_st;
    logic [15:0] b_frames;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] a_exp_frames;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;

    serial_tx_scheduler #(
        .HEARTBEAT_CYCLES(1000000),
        .TIMEOUT_CYCLES  (50)
    ) dut_a (
        .clk_i          (clk),
        .rst_i          (rst_a),
        .result_req_i   (req_a),
        .result_status_i(res_status),
        .hb_status_i    (hb_status),
        .tx_busy_i      (tx_busy),
        .tx_new_data_i  (new_data),
        .transmit_o     (a_tx),
        .header_byte_o  (a_hdr),
        .status_byte_o  (a_st),
        .ram_lock_o     (a_lock),
        .result_ack_o   (a_ack),
        .error_o        (a_err),
        .frames_sent_o  (a_frames)
    );

    serial_tx_scheduler #(
        .HEARTBEAT_CYCLES(100),
        .TIMEOUT_CYCLES  (50)
    ) dut_b (
        .clk_i          (clk),
        .rst_i          (rst_b),
        .result_req_i   (req_b),
        .result_status_i(res_status),
        .hb_status_i    (hb_status),
        .tx_busy_i      (tx_busy),
        .tx_new_data_i  (new_data),
        .transmit_o     (b_tx),
        .header_byte_o  (b_hdr),
        .status_byte_o  (b_st),
        .ram_lock_o     (b_lock),
        .result_ack_o   (b_ack),
        .error_o        (b_err),
        .frames_sent_o  (b_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            new_data = 1'b1;
            tick();
            new_data = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Frame-start scoreboard: each transmit strobe must match the oldest expected frame
    always @(negedge clk) begin
        if (a_tx) begin
            if (qa.size() == 0) begin
                check("a_sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_sb_header", 32'(a_hdr), 32'(ea.hdr));
                check("a_sb_status", 32'(a_st), 32'(ea.st));
            end
        end
        if (b_tx) begin
            if (qb.size() == 0) begin
                check("b_sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_sb_header", 32'(b_hdr), 32'(eb.hdr));
                check("b_sb_status", 32'(b_st), 32'(eb.st));
            end
        end
    end

    // Request a result frame on dut_a and wait (bounded) for its transmit strobe
    task automatic request_a(input logic [7:0] st, input int busy_pre, input int exp_lat);
        int lat;
        res_status = st;
        tx_busy    = (busy_pre > 0);
        req_a      = 1'b1;
        qa.push_back('{hdr: 8'hA5, st: st});
        lat = 0;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            tick();
            if (i == 1) req_a = 1'b0;
            if (i == busy_pre) tx_busy = 1'b0;
            if (a_tx) begin
                lat = i;
            end else if (i >= 2) begin
                check("a_lock_wait", 32'(a_lock), 32'd1);
            end
        end
        check("a_tx_latency", 32'(lat), 32'(exp_lat));
        check("a_lock_at_start", 32'(a_lock), 32'd1);
    endtask

    // Complete a frame on dut_a after its transmit strobe
    task automatic frame_tail_a(input int gap);
        tx_busy = 1'b1;
        tick();
        check("a_tx_one_cycle", 32'(a_tx), 32'd0);
        check("a_err_clear", 32'(a_err), 32'd0);
        strobes(34, gap);
        tick();
        check("a_ack_in_drain", 32'(a_ack), 32'd0);
        check("a_lock_in_drain", 32'(a_lock), 32'd1);
        tx_busy = 1'b0;
        tick();
        check("a_ack_done", 32'(a_ack), 32'd1);
        check("a_lock_done", 32'(a_lock), 32'd1);
        tick();
        check("a_ack_one_cycle", 32'(a_ack), 32'd0);
        check("a_lock_idle", 32'(a_lock), 32'd0);
        a_exp_frames = a_exp_frames + 16'd1;
        check("a_frames", 32'(a_frames), 32'(a_exp_frames));
    endtask

    vec_t vecs[4];

    initial begin
        int   lat;
        logic seen;

        vecs[0] = '{status: 8'h17, busy_pre: 0,  gap: 0, exp_lat: 3};
        vecs[1] = '{status: 8'hC3, busy_pre: 20, gap: 1, exp_lat: 21};
        vecs[2] = '{status: 8'h00, busy_pre: 5,  gap: 2, exp_lat: 6};
        vecs[3] = '{status: 8'hFF, busy_pre: 0,  gap: 3, exp_lat: 3};

        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        res_status = 8'h00; hb_status = 8'h00; tx_busy = 1'b0; new_data = 1'b0;
        a_exp_frames = 16'd0;
        repeat (3) tick();

        check("rst_a_tx", 32'(a_tx), 32'd0);
        check("rst_a_hdr", 32'(a_hdr), 32'd0);
        check("rst_a_st", 32'(a_st), 32'd0);
        check("rst_a_lock", 32'(a_lock), 32'd0);
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_frames", 32'(a_frames), 32'd0);
        check("rst_b_lock", 32'(b_lock), 32'd0);
        check("rst_b_frames", 32'(b_frames), 32'd0);
        rst_a = 1'b0;
        tick();

        // Table of result frames: status, busy hold, strobe spacing, expected latency
        for (int v = 0; v < 4; v++) begin
            request_a(vecs[v].status, vecs[v].busy_pre, vecs[v].exp_lat);
            frame_tail_a(vecs[v].gap);
            repeat (2) tick();
        end

        // Stall timeout after 10 bytes
        request_a(8'h42, 0, 3);
        tx_busy = 1'b1;
        tick();
        strobes(10, 0);
        repeat (45) tick();
        check("to_err_early", 32'(a_err), 32'd0);
        check("to_ack_early", 32'(a_ack), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (a_ack) seen = 1'b1;
        end
        check("to_ack_seen", 32'(seen), 32'd1);
        check("to_err_set", 32'(a_err), 32'd1);
        tick();
        tx_busy = 1'b0;
        check("to_lock_idle", 32'(a_lock), 32'd0);
        check("to_frames_held", 32'(a_frames), 32'(a_exp_frames));
        check("to_err_sticky", 32'(a_err), 32'd1);
        request_a(8'h43, 0, 3);
        frame_tail_a(0);

        // Re-arm: a request mid-frame schedules a second frame; latched status holds
        request_a(8'h11, 0, 3);
        tx_busy = 1'b1;
        tick();
        strobes(5, 0);
        res_status = 8'h22;
        req_a = 1'b1;
        qa.push_back('{hdr: 8'hA5, st: 8'h22});
        tick();
        req_a = 1'b0;
        strobes(29, 0);
        tx_busy = 1'b0;
        tick();
        check("rearm_ack1", 32'(a_ack), 32'd1);
        check("rearm_status_held", 32'(a_st), 32'h11);
        a_exp_frames = a_exp_frames + 16'd1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (a_tx) lat = i;
        end
        check("rearm_second_lat", 32'(lat), 32'd3);
        frame_tail_a(0);

        // Counter wrap from a preloaded 0xFFFF
        @(negedge clk);
        force dut_a.frames_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.frames_cnt_q;
        tick();
        check("wrap_preload", 32'(a_frames), 32'hFFFF);
        a_exp_frames = 16'hFFFF;
        request_a(8'h5E, 0, 3);
        frame_tail_a(0);
        check("wrap_zero", 32'(a_frames), 32'd0);

        // Reset in the middle of a frame
        request_a(8'h99, 0, 3);
        tx_busy = 1'b1;
        tick();
        strobes(7, 0);
        rst_a = 1'b1;
        tick();
        check("mid_rst_tx", 32'(a_tx), 32'd0);
        check("mid_rst_hdr", 32'(a_hdr), 32'd0);
        check("mid_rst_st", 32'(a_st), 32'd0);
        check("mid_rst_lock", 32'(a_lock), 32'd0);
        check("mid_rst_ack", 32'(a_ack), 32'd0);
        check("mid_rst_err", 32'(a_err), 32'd0);
        check("mid_rst_frames", 32'(a_frames), 32'd0);
        rst_a = 1'b0;
        tx_busy = 1'b0;
        a_exp_frames = 16'd0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (a_ack || a_lock || a_tx) seen = 1'b1;
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);
        request_a(8'h66, 0, 3);
        frame_tail_a(0);

        // Priority: result request in the same cycle as heartbeat expiry on dut_b
        res_status = 8'h31;
        hb_status  = 8'h3C;
        tick();
        rst_b = 1'b0;
        repeat (99) tick();
        req_b = 1'b1;
        qb.push_back('{hdr: 8'hA5, st: 8'h31});
        qb.push_back('{hdr: 8'h5A, st: 8'h3C});
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (i == 1) req_b = 1'b0;
            if (b_tx) lat = i;
        end
        check("prio_res_lat", 32'(lat), 32'd3);
        tx_busy = 1'b1;
        tick();
        strobes(34, 0);
        tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (b_ack) seen = 1'b1;
        end
        check("prio_res_ack", 32'(seen), 32'd1);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (b_tx) lat = i;
        end
        check("prio_hb_lat", 32'(lat), 32'd3);
        tx_busy = 1'b1;
        tick();
        strobes(34, 0);
        tx_busy = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (b_ack) seen = 1'b1;
        end
        check("prio_hb_no_ack", 32'(seen), 32'd0);
        check("prio_frames", 32'(b_frames), 32'd2);
        check("prio_lock_idle", 32'(b_lock), 32'd0);
        rst_b = 1'b1;
        tick();

        check("a_sb_drained", 32'(qa.size()), 32'd0);
        check("b_sb_drained", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
- Sequences the serial frame transmitter: decides when a frame is sent, supplies its header and status bytes, and issues the one-cycle transmit strobe.
- Arbitrates two frame sources: a result frame requested by the hash core, and a periodic heartbeat frame.
- Locks the 32-byte result RAM against core writes while a frame is in flight.
- Tracks frame completion by counting the transmitter's byte strobes, with a stall timeout.

Parameters:
- FRAME_BYTES, 34, bytes per frame (header + status + 32 RAM bytes).
- HEARTBEAT_CYCLES, 50000000, clock cycles between heartbeat requests.
- TIMEOUT_CYCLES, 1000000, maximum cycles between byte strobes before a frame is aborted.
- RESULT_HEADER, 8'hA5, header byte for result frames.
- HEARTBEAT_HEADER, 8'h5A, header byte for heartbeat frames.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- result_req_i  in  1  one-cycle pulse from the hash core: a new best result is in RAM.
- result_status_i  in  8  status byte for result frames, sampled when the frame is granted.
- hb_status_i  in  8  status byte for heartbeat frames, sampled when the frame is granted.
- tx_busy_i  in  1  UART busy flag.
- tx_new_data_i  in  1  tap of the transmitter's per-byte new-data strobe.
- transmit_o  out  1  one-cycle frame start strobe to the transmitter.
- header_byte_o  out  8  header byte; stable for the whole frame.
- status_byte_o  out  8  status byte; stable for the whole frame.
- ram_lock_o  out  1  high while a frame owns the RAM; the core must not write while it is high.
- result_ack_o  out  1  one-cycle pulse when a result frame finishes or aborts.
- error_o  out  1  set on a frame timeout; cleared at the next frame start.
- frames_sent_o  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
Reset:
- All outputs are 0, the state is IDLE, and both pending flags, all counters and the heartbeat timer are 0.
- Reset has priority over everything. Reset mid-frame returns to IDLE immediately: ram_lock_o drops, no ack is issued, and the pending flags are cleared.

Pending flags:
- res_pend is set by result_req_i. hb_pend is set when the heartbeat timer reaches HEARTBEAT_CYCLES-1.
- The heartbeat timer is free-running and wraps to 0 on expiry. An expiry while hb_pend is already set is dropped; there is no stacking.
- A flag is cleared in DONE for the frame type just sent. If a set and a clear of the same flag occur in the same cycle, the set wins.

States:
- IDLE: if res_pend, select RESULT; else if hb_pend, select HEARTBEAT (result has strict priority). On a selection, latch the header and the matching status byte into header_byte_o/status_byte_o, then go to LOCK. Otherwise stay in IDLE.
- LOCK: ram_lock_o=1. Wait until tx_busy_i=0, then go to START. The latched bytes are not resampled.
- START: transmit_o=1 for exactly this cycle; clear the byte counter, the timeout counter and error_o; go to COUNT.
- COUNT: each tx_new_data_i pulse increments the byte counter and clears the timeout counter. When the counter reaches FRAME_BYTES, go to DRAIN. If the timeout counter reaches TIMEOUT_CYCLES, set error_o and go to DONE.
- DRAIN: wait for tx_busy_i=0, so the last byte is fully shifted out, then go to DONE.
- DONE: clear the pending flag of the sent type. result_ack_o=1 if the type was RESULT. frames_sent_o increments only on a non-error completion. Go to IDLE.

Output and timing rules:
- ram_lock_o is 1 in LOCK, START, COUNT, DRAIN and DONE; 0 in IDLE.
- Minimum latency: result_req_i at cycle n gives res_pend=1 at n+1, LOCK at n+2, and transmit_o at n+3 if tx_busy_i=0.
- A result_req_i that arrives during a result frame re-arms res_pend, and a second frame follows after DONE.
- Extra tx_new_data_i pulses outside COUNT are ignored.

Test Plan:
- Single result: pulse result_req_i with result_status_i=8'h17, tx_busy_i=0; feed 34 strobes then tx_busy_i low -> transmit_o 3 cycles after the req; header=A5, status=17; result_ack_o pulses once; frames_sent_o=1; ram_lock_o high from LOCK through DONE.
- Priority: assert result_req_i in the same cycle as heartbeat expiry (HEARTBEAT_CYCLES=100) -> result frame (A5) first, then a heartbeat frame (5A) with hb_status_i; frames_sent_o=2.
- Busy hold: hold tx_busy_i=1 for 20 cycles after a request -> stays in LOCK with ram_lock_o=1 and transmit_o=0; transmit_o fires the cycle after busy falls.
- Timeout: TIMEOUT_CYCLES=50, stop strobes after 10 bytes -> error_o=1 at 50 idle cycles; result_ack_o pulses; frames_sent_o unchanged; the next frame start clears error_o.
- Re-arm and wrap: pulse result_req_i mid-frame -> a second result frame follows; preload 65535 completed frames -> frames_sent_o wraps to 0.
- Reset mid-frame: assert rst_i during COUNT -> next cycle all outputs are 0; a later request starts cleanly with no stale ack.
